// File: rtl/fifo_wptr_full_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_wptr_full_ctrl_if
//   Write-side bus of the async FIFO write controller.
//   master : producer / surrounding FIFO logic (drives wr_en, clr_ovf and the
//            synchronized read pointer; observes strobe, address, flags)
//   slave  : fifo_wptr_full_ctrl
//   Signals:
//     wr_en, clr_ovf, rq2_rptr_gray        -> controller
//     mem_we, waddr, wptr_gray, full,
//     overflow                             <- controller
//     almost_full, wr_level                <- controller (FIFO_AFULL_EN only)
// ----------------------------------------------------------------------------
interface fifo_wptr_full_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   rq2_rptr_gray;
    logic                  clr_ovf;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic                  full;
    logic                  overflow;
`ifdef FIFO_AFULL_EN
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_level;
`endif

    modport master (
        output wr_en, rq2_rptr_gray, clr_ovf,
`ifdef FIFO_AFULL_EN
        input  almost_full, wr_level,
`endif
        input  mem_we, waddr, wptr_gray, full, overflow
    );

    modport slave (
        input  wr_en, rq2_rptr_gray, clr_ovf,
`ifdef FIFO_AFULL_EN
        output almost_full, wr_level,
`endif
        output mem_we, waddr, wptr_gray, full, overflow
    );
endinterface

// File: rtl/fifo_wptr_full_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_wptr_full_ctrl
//   Write-domain controller of an asynchronous FIFO. Keeps the binary write
//   pointer (memory address) and the Gray write pointer handed to the read
//   domain, and derives a registered full flag plus a sticky overflow flag
//   from the synchronized read Gray pointer.
//
//   Ports:
//     clk  : write-domain clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : fifo_wptr_full_ctrl_if.slave
//            wr_en / clr_ovf / rq2_rptr_gray in,
//            mem_we (comb) / waddr / wptr_gray / full / overflow out
//
//   Optional feature macro: FIFO_AFULL_EN
//     Adds parameter AFULL_THRESH and the almost_full / wr_level outputs,
//     computed from a Gray-to-binary conversion of the read pointer.
// ----------------------------------------------------------------------------
module fifo_wptr_full_ctrl #(
    parameter int ADDR_WIDTH = 4
`ifdef FIFO_AFULL_EN
    ,
    parameter int AFULL_THRESH = 12
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wptr_full_ctrl_if.slave  bus
);
    localparam int A = ADDR_WIDTH;

    logic [A:0] wptr_bin;
    logic [A:0] wptr_gray_q;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] rq2_full_cmp;
    logic       full_q;
    logic       ovf_q;
    logic       accept;
    logic       full_next;

    // full_q is registered, so mem_we has no path from rq2_rptr_gray.
    assign accept     = bus.wr_en & ~full_q & ~rst;
    assign wbin_next  = wptr_bin + {{A{1'b0}}, accept};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // In Gray code, "write is exactly one lap ahead" means the top two bits
    // are inverted and the rest equal.
    assign rq2_full_cmp = {~bus.rq2_rptr_gray[A:A-1], bus.rq2_rptr_gray[A-2:0]};
    assign full_next    = (wgray_next == rq2_full_cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_bin    <= '0;
            wptr_gray_q <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wptr_bin    <= wbin_next;
            wptr_gray_q <= wgray_next;
            full_q      <= full_next;
            // Set has priority over clear.
            if (bus.wr_en & full_q)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign bus.mem_we    = accept;
    assign bus.waddr     = wptr_bin[A-1:0];
    assign bus.wptr_gray = wptr_gray_q;
    assign bus.full      = full_q;
    assign bus.overflow  = ovf_q;

`ifdef FIFO_AFULL_EN
    localparam logic [A:0] AF_TH = AFULL_THRESH[A:0];

    logic [A:0] rbin;
    logic [A:0] lvl_next;
    logic [A:0] lvl_q;
    logic       af_q;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= A; i++)
            rbin[i] = ^(bus.rq2_rptr_gray >> i);
    end

    // Uses the lagging read pointer, so the level can only over-report.
    assign lvl_next = wbin_next - rbin;

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= '0;
            af_q  <= 1'b0;
        end else begin
            lvl_q <= lvl_next;
            af_q  <= (lvl_next >= AF_TH);
        end
    end

    assign bus.wr_level    = lvl_q;
    assign bus.almost_full = af_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
module tb_fifo_wptr_full_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fifo_wptr_full_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    fifo_wptr_full_ctrl #(.ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: occupancy arithmetic on plain integers.
    int m_w;     // write count modulo 32
    int m_full;
    int m_ovf;
    int m_lvl;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    // Inverse Gray by search over all 32 codes.
    function automatic int g2b(input logic [4:0] g);
        for (int n = 0; n < 32; n++)
            if (gray(n) == g) return n;
        return 0;
    endfunction

    // Advance the model using the inputs currently applied, then clock once.
    task automatic tick();
        int rb;
        int d;
        if (rst) begin
            m_w = 0; m_full = 0; m_ovf = 0; m_lvl = 0;
        end else begin
            if (bus.wr_en && m_full != 0) m_ovf = 1;
            else if (bus.clr_ovf)         m_ovf = 0;
            if (bus.wr_en && m_full == 0) m_w = (m_w + 1) % 32;
            rb     = g2b(bus.rq2_rptr_gray);
            d      = (m_w - rb + 32) % 32;
            m_full = (d == 16) ? 1 : 0;
            m_lvl  = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.wr_en = 1'b1; bus.clr_ovf = 1'b0; bus.rq2_rptr_gray = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.mem_we !== 1'b0) begin
                errors++; $display("FAIL reset_mem_we cyc %0d got %b exp 0", i, bus.mem_we);
            end
            tick();
            checks++;
            if (bus.wptr_gray !== 5'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.waddr !== 4'd0) begin
                errors++;
                $display("FAIL reset_state cyc %0d got gray %b full %b ovf %b waddr %0d exp all 0",
                         i, bus.wptr_gray, bus.full, bus.overflow, bus.waddr);
            end
        end
        rst = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic test_fill();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (bus.mem_we !== 1'b1 || bus.waddr !== 4'(i) || bus.full !== 1'b0) begin
                errors++;
                $display("FAIL fill_write %0d got we %b waddr %0d full %b exp we 1 waddr %0d full 0",
                         i, bus.mem_we, bus.waddr, bus.full, i);
            end
            tick();
            checks++;
            if (bus.wptr_gray !== gray(m_w) || bus.full !== m_full[0]) begin
                errors++;
                $display("FAIL fill_ptr %0d got gray %b full %b exp gray %b full %0d",
                         i, bus.wptr_gray, bus.full, gray(m_w), m_full);
            end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.wptr_gray !== 5'b11000) begin
            errors++;
            $display("FAIL fill_final got full %b gray %b exp 1 11000", bus.full, bus.wptr_gray);
        end
    endtask

    task automatic test_overflow();
        bus.wr_en = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL ovf_mem_we got %b exp 0", bus.mem_we);
        end
        tick();
        checks++;
        if (bus.overflow !== 1'b1 || bus.wptr_gray !== 5'b11000 || bus.waddr !== 4'd0 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got ovf %b gray %b waddr %0d full %b exp 1 11000 0 1",
                     bus.overflow, bus.wptr_gray, bus.waddr, bus.full);
        end
        bus.wr_en = 1'b0; bus.clr_ovf = 1'b1;
        tick();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow);
        end
        bus.wr_en = 1'b1; bus.clr_ovf = 1'b1;
        tick();
        checks++;
        if (bus.overflow !== 1'b1 || bus.overflow !== m_ovf[0]) begin
            errors++; $display("FAIL ovf_set_wins got %b exp 1", bus.overflow);
        end
        bus.wr_en = 1'b0; bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
    endtask

    task automatic test_drain();
        bus.rq2_rptr_gray = 5'b00110;
        tick();
        checks++;
        if (bus.full !== 1'b0) begin
            errors++; $display("FAIL drain_release got full %b exp 0", bus.full);
        end
        bus.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.mem_we !== 1'b1 || bus.waddr !== 4'(i)) begin
                errors++;
                $display("FAIL drain_write %0d got we %b waddr %0d exp 1 %0d", i, bus.mem_we, bus.waddr, i);
            end
            tick();
        end
        bus.wr_en = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.wptr_gray !== gray(20) || m_w != 20) begin
            errors++;
            $display("FAIL drain_refill got full %b gray %b exp 1 %b", bus.full, bus.wptr_gray, gray(20));
        end
    endtask

    task automatic test_wrap();
        int r;
        r = 4;
        for (int i = 0; i < 12; i++) begin
            r = (r + 1) % 32;
            bus.rq2_rptr_gray = gray(r);
            bus.wr_en = 1'b0;
            tick();
            checks++;
            if (bus.full !== 1'b0) begin
                errors++; $display("FAIL wrap_read_release %0d got full %b exp 0", i, bus.full);
            end
            bus.wr_en = 1'b1;
            #1;
            if (i == 11) begin
                checks++;
                if (bus.wptr_gray !== 5'b10000) begin
                    errors++; $display("FAIL wrap_pre got gray %b exp 10000", bus.wptr_gray);
                end
            end
            tick();
            checks++;
            if (bus.full !== 1'b1 || bus.wptr_gray !== gray(m_w)) begin
                errors++;
                $display("FAIL wrap_write %0d got full %b gray %b exp 1 %b", i, bus.full, bus.wptr_gray, gray(m_w));
            end
        end
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wptr_gray !== 5'b00000) begin
            errors++; $display("FAIL wrap_post got gray %b exp 00000", bus.wptr_gray);
        end
        // Read catches up completely: equal pointers mean empty, never full.
        for (int i = 0; i < 16; i++) begin
            r = (r + 1) % 32;
            bus.rq2_rptr_gray = gray(r);
            tick();
        end
        checks++;
        if (bus.full !== 1'b0 || bus.wptr_gray !== bus.rq2_rptr_gray) begin
            errors++;
            $display("FAIL alias_equal got full %b wgray %b rgray %b exp full 0", bus.full, bus.wptr_gray, bus.rq2_rptr_gray);
        end
        bus.wr_en = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.full !== 1'b1) begin
            errors++; $display("FAIL alias_diff16 got full %b exp 1", bus.full);
        end
    endtask

    task automatic test_random();
        int r;
        logic exp_we;
        r = g2b(bus.rq2_rptr_gray);
        for (int i = 0; i < 400; i++) begin
            bus.wr_en   = ($urandom_range(0, 3) != 0);
            bus.clr_ovf = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0 && r != m_w) r = (r + 1) % 32;
            bus.rq2_rptr_gray = gray(r);
            exp_we = bus.wr_en && (m_full == 0);
            #1;
            checks++;
            if (bus.mem_we !== exp_we || bus.waddr !== 4'(m_w % 16)) begin
                errors++;
                $display("FAIL rand_we %0d got we %b waddr %0d exp %b %0d", i, bus.mem_we, bus.waddr, exp_we, m_w % 16);
            end
            tick();
            checks++;
            if (bus.wptr_gray !== gray(m_w) || bus.full !== m_full[0] || bus.overflow !== m_ovf[0]) begin
                errors++;
                $display("FAIL rand_state %0d got gray %b full %b ovf %b exp %b %0d %0d",
                         i, bus.wptr_gray, bus.full, bus.overflow, gray(m_w), m_full, m_ovf);
            end
`ifdef FIFO_AFULL_EN
            checks++;
            if (bus.wr_level !== 5'(m_lvl) || bus.almost_full !== (m_lvl >= 12)) begin
                errors++;
                $display("FAIL rand_level %0d got lvl %0d af %b exp %0d %b",
                         i, bus.wr_level, bus.almost_full, m_lvl, (m_lvl >= 12));
            end
`endif
        end
        bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
    endtask

`ifdef FIFO_AFULL_EN
    task automatic test_afull();
        rst = 1'b1; bus.rq2_rptr_gray = '0; bus.wr_en = 1'b0;
        tick();
        rst = 1'b0; bus.wr_en = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (bus.almost_full !== 1'b0 || bus.wr_level !== 5'd11) begin
            errors++; $display("FAIL afull_11 got af %b lvl %0d exp 0 11", bus.almost_full, bus.wr_level);
        end
        tick();
        checks++;
        if (bus.almost_full !== 1'b1 || bus.wr_level !== 5'd12) begin
            errors++; $display("FAIL afull_12 got af %b lvl %0d exp 1 12", bus.almost_full, bus.wr_level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.wr_en = 1'b0;
        checks++;
        if (bus.almost_full !== 1'b0 || bus.wr_level !== 5'd0) begin
            errors++; $display("FAIL afull_reset got af %b lvl %0d exp 0 0", bus.almost_full, bus.wr_level);
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        m_w = 0; m_full = 0; m_ovf = 0; m_lvl = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_random();
`ifdef FIFO_AFULL_EN
        test_afull();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
